ex_mem_stage: RTL and testbench

- Pipeline register between the execute stage (ALU output, NZCV flags) and the memory stage.
- Holds the architectural NZCV status register and evaluates each instruction's 4-bit condition code against it.
- Condition-failed instructions pass down the pipe with every side effect suppressed.
- Supports stall and flush.

---
 rtl/ex_mem_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Holds the architectural NZCV register, evaluates
// each instruction's condition code against it, and suppresses all side
// effects of condition-failed instructions. Priority: flush > stall > capture.
module ex_mem_stage #(
    parameter int N  = 32,
    parameter int RA = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [N-1:0]  alu_result_i,
    input  logic [3:0]    flags_i,
    input  logic [3:0]    cond_i,
    input  logic          setflags_i,
    input  logic          regwrite_i,
    input  logic          memwrite_i,
    input  logic          memtoreg_i,
    input  logic [RA-1:0] wa_i,
    input  logic [N-1:0]  write_data_i,
    output logic          valid_o,
    output logic [N-1:0]  alu_result_o,
    output logic [N-1:0]  write_data_o,
    output logic [RA-1:0] wa_o,
    output logic          regwrite_o,
    output logic          memwrite_o,
    output logic          memtoreg_o,
    output logic          cond_pass_o,
    output logic [3:0]    nzcv_o
);

    logic          valid_q,     valid_d;
    logic [N-1:0]  alu_q,       alu_d;
    logic [N-1:0]  wdata_q,     wdata_d;
    logic [RA-1:0] wa_q,        wa_d;
    logic          regwrite_q,  regwrite_d;
    logic          memwrite_q,  memwrite_d;
    logic          memtoreg_q,  memtoreg_d;
    logic          cond_pass_q, cond_pass_d;
    logic [3:0]    nzcv_q,      nzcv_d;
    logic          cond_ex;

    logic f_n, f_z, f_c, f_v;
    assign {f_n, f_z, f_c, f_v} = nzcv_q;

    // Condition evaluated against the current NZCV, before this instruction's own update
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_i)
            4'b0000: cond_ex = f_z;
            4'b0001: cond_ex = !f_z;
            4'b0010: cond_ex = f_c;
            4'b0011: cond_ex = !f_c;
            4'b0100: cond_ex = f_n;
            4'b0101: cond_ex = !f_n;
            4'b0110: cond_ex = f_v;
            4'b0111: cond_ex = !f_v;
            4'b1000: cond_ex = f_c && !f_z;
            4'b1001: cond_ex = !f_c || f_z;
            4'b1010: cond_ex = (f_n == f_v);
            4'b1011: cond_ex = (f_n != f_v);
            4'b1100: cond_ex = !f_z && (f_n == f_v);
            4'b1101: cond_ex = f_z || (f_n != f_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Next-state selection: flush clears control only, stall holds everything
    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        wdata_d     = wdata_q;
        wa_d        = wa_q;
        regwrite_d  = regwrite_q;
        memwrite_d  = memwrite_q;
        memtoreg_d  = memtoreg_q;
        cond_pass_d = cond_pass_q;
        nzcv_d      = nzcv_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            memwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
            cond_pass_d = 1'b0;
        end else if (!stall_i) begin
            valid_d     = valid_i;
            alu_d       = alu_result_i;
            wdata_d     = write_data_i;
            wa_d        = wa_i;
            cond_pass_d = valid_i && cond_ex;
            regwrite_d  = regwrite_i && valid_i && cond_ex;
            memwrite_d  = memwrite_i && valid_i && cond_ex;
            memtoreg_d  = memtoreg_i && valid_i;
            if (valid_i && setflags_i && cond_ex)
                nzcv_d = flags_i;
        end
    end

    // Stage registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            wdata_q     <= '0;
            wa_q        <= '0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            cond_pass_q <= 1'b0;
            nzcv_q      <= 4'b0000;
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            wdata_q     <= wdata_d;
            wa_q        <= wa_d;
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            memtoreg_q  <= memtoreg_d;
            cond_pass_q <= cond_pass_d;
            nzcv_q      <= nzcv_d;
        end
    end

    assign valid_o      = valid_q;
    assign alu_result_o = alu_q;
    assign write_data_o = wdata_q;
    assign wa_o         = wa_q;
    assign regwrite_o   = regwrite_q;
    assign memwrite_o   = memwrite_q;
    assign memtoreg_o   = memtoreg_q;
    assign cond_pass_o  = cond_pass_q;
    assign nzcv_o       = nzcv_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: flag setting, condition gating, stall,
// flush, signed compares, bubbles and asynchronous reset.
module tb_ex_mem_stage;

    localparam int N  = 32;
    localparam int RA = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall_i, flush_i, valid_i;
    logic [N-1:0]  alu_result_i, write_data_i;
    logic [3:0]    flags_i, cond_i;
    logic          setflags_i, regwrite_i, memwrite_i, memtoreg_i;
    logic [RA-1:0] wa_i;
    logic          valid_o, regwrite_o, memwrite_o, memtoreg_o, cond_pass_o;
    logic [N-1:0]  alu_result_o, write_data_o;
    logic [RA-1:0] wa_o;
    logic [3:0]    nzcv_o;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, HI = 4'b1000, LS = 4'b1001;
    localparam logic [3:0] GE = 4'b1010, LT = 4'b1011, AL = 4'b1110, NV = 4'b1111;

    ex_mem_stage #(.N(N), .RA(RA)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .alu_result_i(alu_result_i), .flags_i(flags_i),
        .cond_i(cond_i), .setflags_i(setflags_i), .regwrite_i(regwrite_i),
        .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i), .wa_i(wa_i),
        .write_data_i(write_data_i), .valid_o(valid_o), .alu_result_o(alu_result_o),
        .write_data_o(write_data_o), .wa_o(wa_o), .regwrite_o(regwrite_o),
        .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o), .cond_pass_o(cond_pass_o),
        .nzcv_o(nzcv_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; flush_i = 0; valid_i = 1; setflags_i = 0;
        regwrite_i = 0; memwrite_i = 0; memtoreg_i = 0; cond_i = AL;
        flags_i = 4'b0000; alu_result_i = '0; write_data_i = '0; wa_i = '0;
    endtask

    // load NZCV through an always-executed flag setter
    task automatic set_nzcv(input logic [3:0] f);
        idle(); setflags_i = 1; flags_i = f;
        step();
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("reset_valid", 32'(valid_o), 0);
        chk("reset_nzcv", 32'(nzcv_o), 0);
        chk("reset_alu", alu_result_o, 0);
        @(negedge clk);
        rst_n = 1;

        // flag setter then conditional consumers
        idle(); setflags_i = 1; flags_i = 4'b0100; alu_result_i = 32'h11; regwrite_i = 1;
        step();
        chk("fs_nzcv", 32'(nzcv_o), 32'h4);
        chk("fs_valid", 32'(valid_o), 1);
        idle(); cond_i = EQ; regwrite_i = 1; wa_i = 4'd7;
        step();
        chk("eq_regwrite", 32'(regwrite_o), 1);
        chk("eq_cond_pass", 32'(cond_pass_o), 1);
        chk("eq_wa", 32'(wa_o), 7);
        idle(); cond_i = NE; regwrite_i = 1; memtoreg_i = 1;
        step();
        chk("ne_regwrite", 32'(regwrite_o), 0);
        chk("ne_valid", 32'(valid_o), 1);
        chk("ne_cond_pass", 32'(cond_pass_o), 0);
        chk("ne_memtoreg", 32'(memtoreg_o), 1);

        // failed condition suppresses flags and memory write
        set_nzcv(4'b0000);
        chk("clr_nzcv", 32'(nzcv_o), 0);
        idle(); cond_i = EQ; setflags_i = 1; flags_i = 4'b1001; memwrite_i = 1;
        alu_result_i = 32'hABCD; write_data_i = 32'h55;
        step();
        chk("cf_nzcv", 32'(nzcv_o), 0);
        chk("cf_memwrite", 32'(memwrite_o), 0);
        chk("cf_alu", alu_result_o, 32'hABCD);
        chk("cf_wdata", write_data_o, 32'h55);

        // stall holds contents and NZCV
        idle(); alu_result_i = 32'h1234;
        step();
        chk("st_load", alu_result_o, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            idle(); stall_i = 1; setflags_i = 1; flags_i = 4'b1111;
            alu_result_i = 32'h100 + 32'(i);
            step();
            chk("st_hold_alu", alu_result_o, 32'h1234);
            chk("st_hold_nzcv", 32'(nzcv_o), 0);
        end
        idle(); alu_result_i = 32'h5678;
        step();
        chk("st_release", alu_result_o, 32'h5678);

        // flush beats stall
        idle(); flush_i = 1; stall_i = 1; setflags_i = 1; flags_i = 4'b0110;
        regwrite_i = 1; alu_result_i = 32'h9999;
        step();
        chk("fl_valid", 32'(valid_o), 0);
        chk("fl_regwrite", 32'(regwrite_o), 0);
        chk("fl_nzcv", 32'(nzcv_o), 0);
        chk("fl_alu_hold", alu_result_o, 32'h5678);

        // signed and unsigned compares
        set_nzcv(4'b1001);
        chk("sg_nzcv", 32'(nzcv_o), 32'h9);
        idle(); cond_i = GE;
        step();
        chk("ge_pass", 32'(cond_pass_o), 1);
        idle(); cond_i = LT;
        step();
        chk("lt_fail", 32'(cond_pass_o), 0);
        set_nzcv(4'b0010);
        idle(); cond_i = HI;
        step();
        chk("hi_pass", 32'(cond_pass_o), 1);
        set_nzcv(4'b0110);
        idle(); cond_i = LS;
        step();
        chk("ls_pass", 32'(cond_pass_o), 1);
        idle(); cond_i = HI;
        step();
        chk("hi_fail", 32'(cond_pass_o), 0);
        idle(); cond_i = NV; regwrite_i = 1;
        step();
        chk("nv_fail", 32'(cond_pass_o), 0);
        chk("nv_regwrite", 32'(regwrite_o), 0);
        chk("nv_valid", 32'(valid_o), 1);

        // bubble: no side effects
        idle(); valid_i = 0; regwrite_i = 1; memtoreg_i = 1; setflags_i = 1; flags_i = 4'b1111;
        step();
        chk("bb_valid", 32'(valid_o), 0);
        chk("bb_regwrite", 32'(regwrite_o), 0);
        chk("bb_memtoreg", 32'(memtoreg_o), 0);
        chk("bb_nzcv", 32'(nzcv_o), 32'h6);

        // back-to-back flag setters: second sees first's Z
        set_nzcv(4'b0100);
        idle(); cond_i = EQ; setflags_i = 1; flags_i = 4'b1000;
        step();
        chk("b2b_pass", 32'(cond_pass_o), 1);
        chk("b2b_nzcv", 32'(nzcv_o), 32'h8);
        idle(); cond_i = EQ; regwrite_i = 1;
        step();
        chk("b2b_eq_fail", 32'(regwrite_o), 0);

        // asynchronous reset mid-cycle with live traffic
        idle(); regwrite_i = 1; memwrite_i = 1; setflags_i = 1; flags_i = 4'b1111;
        alu_result_i = 32'hFEED;
        step();
        chk("ar_pre_regwrite", 32'(regwrite_o), 1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_valid", 32'(valid_o), 0);
        chk("ar_regwrite", 32'(regwrite_o), 0);
        chk("ar_memwrite", 32'(memwrite_o), 0);
        chk("ar_alu", alu_result_o, 0);
        chk("ar_nzcv", 32'(nzcv_o), 0);
        chk("ar_cond_pass", 32'(cond_pass_o), 0);
        @(negedge clk);
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
